// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - shared geometry constants, FSM states and address helpers
package vga_fb_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int PX_W     = 3;
    localparam int AW       = 15;
    localparam int XW       = 8;
    localparam int YW       = 7;
    localparam int LB_DEPTH = 2 * FB_W;
    localparam int LBAW     = XW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Linear RAM address of the first pixel of a row.
    function automatic logic [AW-1:0] row_base(input logic [YW-1:0] row);
        return AW'(row) * AW'(FB_W);
    endfunction

    // Flat line-buffer address: bank 1 occupies the upper FB_W entries.
    function automatic logic [LBAW-1:0] lb_index(input logic bank, input logic [XW-1:0] idx);
        return (bank ? LBAW'(FB_W) : LBAW'(0)) + LBAW'(idx);
    endfunction

endpackage

// File: rtl/vga_line_buffer.sv
// rtl/vga_line_buffer.sv - two-bank ping-pong line buffer, one write and one registered read port
module vga_line_buffer
    import vga_fb_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_wr_en,
    input  logic            i_wr_bank,
    input  logic [XW-1:0]   i_wr_idx,
    input  logic [PX_W-1:0] i_wr_data,
    input  logic            i_rd_bank,
    input  logic [XW-1:0]   i_rd_idx,
    output logic [PX_W-1:0] o_rd_data
);

    logic [PX_W-1:0] r_mem [LB_DEPTH];
    logic [PX_W-1:0] r_rd_data;

    // Fill-side write; contents are deliberately not reset so this maps onto RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[lb_index(i_wr_bank, i_wr_idx)] <= i_wr_data;
        end
    end

    // Display-side read with one cycle of latency.
    always_ff @(posedge i_clk) begin
        r_rd_data <= r_mem[lb_index(i_rd_bank, i_rd_idx)];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shares the framebuffer RAM port between row bursts and a drawing writer
module vga_fb_arbiter
    import vga_fb_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_fetch_req,
    input  logic [YW-1:0]   i_fetch_row,
    output logic            o_fetch_done,
    input  logic [XW-1:0]   i_vid_rd_x,
    output logic [PX_W-1:0] o_vid_rd_px,
    input  logic            i_wr_valid,
    output logic            o_wr_ready,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [PX_W-1:0] i_wr_data,
    output logic [AW-1:0]   o_mem_addr,
    output logic            o_mem_we,
    output logic [PX_W-1:0] o_mem_wdata,
    input  logic [PX_W-1:0] i_mem_rdata,
    output logic            o_err_overrun,
    output logic            o_err_row
);

    localparam logic [AW-1:0] FB_PIXELS = AW'(FB_W * FB_H);
    localparam logic [XW-1:0] ROW_PX    = XW'(FB_W);
    localparam logic [XW-1:0] LAST_X    = XW'(FB_W - 1);
    localparam logic [YW-1:0] ROWS      = YW'(FB_H);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_base;
    logic [XW-1:0]   r_cnt;
    logic            r_fill_bank;
    logic            r_disp_bank;
    logic            r_cap_en;
    logic [XW-1:0]   r_cap_idx;
    logic            r_fetch_done;
    logic            r_err_overrun;
    logic            r_err_row;
    logic            r_rd_zero;

    logic            w_row_ok;
    logic            w_start;
    logic            w_wr_ready;
    logic            w_wr_fire;
    logic            w_wr_in_range;
    logic [XW-1:0]   w_rd_idx;
    logic [PX_W-1:0] w_lb_rd_data;
    logic [AW-1:0]   w_mem_addr;
    logic            w_mem_we;
    logic [PX_W-1:0] w_mem_wdata;

    assign w_row_ok      = (i_fetch_row < ROWS);
    assign w_start       = (r_state == IDLE) && i_fetch_req && w_row_ok;
    // A fetch request in the same cycle always takes the port from the writer.
    assign w_wr_ready    = !i_rst && (r_state == IDLE) && !i_fetch_req;
    assign w_wr_fire     = w_wr_ready && i_wr_valid;
    assign w_wr_in_range = (i_wr_addr < FB_PIXELS);
    // Out-of-row reads are forced to zero at the output; keep the RAM index legal.
    assign w_rd_idx      = (i_vid_rd_x < ROW_PX) ? i_vid_rd_x : '0;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and RAM port drive: burst owns the port in FETCH, writer only in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_addr  = '0;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = FETCH;
                end else if (w_wr_fire && w_wr_in_range) begin
                    w_mem_addr  = i_wr_addr;
                    w_mem_we    = 1'b1;
                    w_mem_wdata = i_wr_data;
                end
            end
            FETCH: begin
                w_mem_addr = r_base + AW'(r_cnt);
                if (r_cnt == LAST_X) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Burst base, pixel counter and ping-pong bank selection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_base      <= '0;
            r_cnt       <= '0;
            r_fill_bank <= 1'b0;
            r_disp_bank <= 1'b1;
        end else if (w_start) begin
            r_base      <= row_base(i_fetch_row);
            r_cnt       <= '0;
            r_disp_bank <= r_fill_bank;
            r_fill_bank <= ~r_fill_bank;
        end else if (r_state == FETCH) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Track which line-buffer slot the RAM data arriving next cycle belongs to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cap_en  <= 1'b0;
            r_cap_idx <= '0;
        end else begin
            r_cap_en  <= (r_state == FETCH);
            r_cap_idx <= r_cnt;
        end
    end

    // Completion pulse and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_done  <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_row     <= 1'b0;
        end else begin
            r_fetch_done <= (r_state == DRAIN);
            if (i_fetch_req && (r_state != IDLE)) begin
                r_err_overrun <= 1'b1;
            end
            if (i_fetch_req && (r_state == IDLE) && !w_row_ok) begin
                r_err_row <= 1'b1;
            end
        end
    end

    // Remember whether the read issued this cycle was outside the row.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_zero <= 1'b1;
        end else begin
            r_rd_zero <= (i_vid_rd_x >= ROW_PX);
        end
    end

    vga_line_buffer u_line_buffer (
        .i_clk     (i_clk),
        .i_wr_en   (r_cap_en),
        .i_wr_bank (r_fill_bank),
        .i_wr_idx  (r_cap_idx),
        .i_wr_data (i_mem_rdata),
        .i_rd_bank (r_disp_bank),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_lb_rd_data)
    );

    assign o_fetch_done  = r_fetch_done;
    assign o_vid_rd_px   = r_rd_zero ? '0 : w_lb_rd_data;
    assign o_wr_ready    = w_wr_ready;
    assign o_mem_addr    = w_mem_addr;
    assign o_mem_we      = w_mem_we;
    assign o_mem_wdata   = w_mem_wdata;
    assign o_err_overrun = r_err_overrun;
    assign o_err_row     = r_err_row;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - randomized self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

    localparam int FB_W = 160;
    localparam int FB_H = 120;
    localparam int NPIX = FB_W * FB_H;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [6:0]  fetch_row;
    logic        fetch_done;
    logic [7:0]  vid_rd_x;
    logic [2:0]  vid_rd_px;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata = 3'd0;
    logic        err_overrun;
    logic        err_row;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_fetch_req   (fetch_req),
        .i_fetch_row   (fetch_row),
        .o_fetch_done  (fetch_done),
        .i_vid_rd_x    (vid_rd_x),
        .o_vid_rd_px   (vid_rd_px),
        .i_wr_valid    (wr_valid),
        .o_wr_ready    (wr_ready),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .o_mem_addr    (mem_addr),
        .o_mem_we      (mem_we),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .o_err_overrun (err_overrun),
        .o_err_row     (err_row)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Framebuffer RAM environment, driven only by the DUT port.
    logic [2:0] ram [NPIX];
    always @(posedge clk) begin
        if (mem_we && int'(mem_addr) < NPIX) ram[int'(mem_addr)] <= mem_wdata;
        mem_rdata <= (int'(mem_addr) < NPIX) ? ram[int'(mem_addr)] : 3'd0;
    end

    // Reference model: framebuffer image, line-buffer banks and burst timing.
    logic [2:0] mram [NPIX];
    logic [2:0] lb   [2][FB_W];
    bit         lbk  [2][FB_W];
    logic [2:0] snap [FB_W];
    bit         m_busy     = 1'b0;
    int         m_t0       = 0;
    int         m_base     = 0;
    int         m_fill     = 0;
    int         m_disp     = 1;
    bit         m_ov       = 1'b0;
    bit         m_row_err  = 1'b0;
    int         m_done_at  = -1;
    logic [2:0] m_px       = 3'd0;
    bit         m_px_known = 1'b1;

    always @(posedge clk) begin
        int c;
        bit busy_now;
        bit ready;
        c = cyc;
        if (rst) begin
            if (m_busy) for (int x = 0; x < FB_W; x++) lbk[m_fill][x] = 1'b0;
            m_busy = 1'b0; m_fill = 0; m_disp = 1;
            m_ov = 1'b0; m_row_err = 1'b0; m_done_at = -1;
            m_px = 3'd0; m_px_known = 1'b1;
        end else begin
            if (int'(vid_rd_x) >= FB_W) begin
                m_px = 3'd0; m_px_known = 1'b1;
            end else begin
                m_px = lb[m_disp][int'(vid_rd_x)];
                m_px_known = lbk[m_disp][int'(vid_rd_x)];
            end
            busy_now = m_busy;
            ready = !busy_now && !fetch_req;
            if (ready && wr_valid && int'(wr_addr) < NPIX) mram[int'(wr_addr)] = wr_data;
            if (fetch_req) begin
                if (busy_now) m_ov = 1'b1;
                else if (int'(fetch_row) >= FB_H) m_row_err = 1'b1;
                else begin
                    m_t0 = c;
                    m_base = int'(fetch_row) * FB_W;
                    m_disp = m_fill;
                    m_fill = 1 - m_fill;
                    m_busy = 1'b1;
                    for (int x = 0; x < FB_W; x++) snap[x] = mram[m_base + x];
                end
            end
            if (busy_now && c == m_t0 + FB_W + 1) begin
                for (int x = 0; x < FB_W; x++) begin
                    lb[m_fill][x] = snap[x];
                    lbk[m_fill][x] = 1'b1;
                end
                m_busy = 1'b0;
                m_done_at = c + 1;
            end
        end
        cyc = cyc + 1;
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        bit erdy;
        int eaddr;
        int ewe;
        int ewd;
        if (cyc >= 1) begin
            erdy = !rst && !m_busy && !fetch_req;
            eaddr = 0; ewe = 0; ewd = 0;
            if (m_busy && cyc <= m_t0 + FB_W) begin
                eaddr = m_base + cyc - m_t0 - 1;
            end else if (erdy && wr_valid && int'(wr_addr) < NPIX) begin
                eaddr = int'(wr_addr); ewe = 1; ewd = int'(wr_data);
            end
            check("wr_ready", int'(wr_ready), int'(erdy));
            check("mem_addr", int'(mem_addr), eaddr);
            check("mem_we", int'(mem_we), ewe);
            check("mem_wdata", int'(mem_wdata), ewd);
            check("fetch_done", int'(fetch_done), int'(cyc == m_done_at));
            check("err_overrun", int'(err_overrun), int'(m_ov));
            check("err_row", int'(err_row), int'(m_row_err));
            if (m_px_known) check("vid_rd_px", int'(vid_rd_px), int'(m_px));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound);
        bit found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (fetch_done) found = 1'b1;
            tick();
        end
        check("done_within_bound", int'(found), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_done;
        bit  acc;
        rst = 1'b1; fetch_req = 1'b0; fetch_row = '0; vid_rd_x = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        for (int a = 0; a < NPIX; a++) begin
            ram[a]  = 3'(a & 7);
            mram[a] = 3'(a & 7);
        end

        // Reset: outputs idle while held, writer ready once released.
        tick(); tick();
        @(negedge clk);
        check("rst_outputs", int'({fetch_done, vid_rd_px, wr_ready, mem_addr, mem_we, mem_wdata, err_overrun, err_row}), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", int'(wr_ready), 1);

        // Row 5 burst: addresses 800..959, done two cycles after the last address.
        fetch_req = 1'b1; fetch_row = 7'd5;
        tick(); fetch_req = 1'b0;
        @(negedge clk); check("fetch_first_addr", int'(mem_addr), 800);
        repeat (159) tick();
        @(negedge clk); check("fetch_last_addr", int'(mem_addr), 959);
        check("fetch_last_we", int'(mem_we), 0);
        tick(); @(negedge clk); check("done_not_early", int'(fetch_done), 0);
        tick(); @(negedge clk); check("done_at_T162", int'(fetch_done), 1);
        // Next fetch swaps row 5 onto the display side.
        tick();
        fetch_req = 1'b1; fetch_row = 7'd0; vid_rd_x = 8'd7;
        tick(); fetch_req = 1'b0;
        tick(); @(negedge clk); check("px_row5_x7", int'(vid_rd_px), 7);
        wait_done(200);

        // Writer collides with a fetch request and waits out the whole burst.
        fetch_req = 1'b1; fetch_row = 7'd3;
        wr_valid = 1'b1; wr_addr = 15'd1234; wr_data = 3'd5;
        @(negedge clk); check("coll_ready_T", int'(wr_ready), 0);
        tick(); fetch_req = 1'b0;
        repeat (160) tick();
        @(negedge clk); check("coll_ready_drain", int'(wr_ready), 0);
        tick(); @(negedge clk);
        check("coll_ready_T162", int'(wr_ready), 1);
        check("coll_we", int'(mem_we), 1);
        check("coll_addr", int'(mem_addr), 1234);
        check("coll_wdata", int'(mem_wdata), 5);
        tick(); wr_valid = 1'b0;

        // Overrun during a burst, then an out-of-range row.
        fetch_req = 1'b1; fetch_row = 7'd10;
        tick(); fetch_req = 1'b0;
        repeat (4) tick();
        fetch_req = 1'b1; fetch_row = 7'd2;
        tick(); fetch_req = 1'b0;
        @(negedge clk); check("err_overrun_set", int'(err_overrun), 1);
        check("burst_unaffected", int'(mem_addr), 1600 + 5);
        wait_done(200);
        fetch_req = 1'b1; fetch_row = 7'd120;
        tick(); fetch_req = 1'b0;
        @(negedge clk); check("err_row_set", int'(err_row), 1);
        check("bad_row_no_burst", int'(wr_ready), 1);

        // Bounds: dropped write and out-of-row read.
        wr_valid = 1'b1; wr_addr = 15'd19200; wr_data = 3'd7;
        @(negedge clk);
        check("oob_wr_ready", int'(wr_ready), 1);
        check("oob_wr_we", int'(mem_we), 0);
        vid_rd_x = 8'd200;
        tick(); wr_valid = 1'b0;
        @(negedge clk); check("oob_rd_px", int'(vid_rd_px), 0);

        // Reset in the middle of a burst.
        fetch_req = 1'b1; fetch_row = 7'd20;
        tick(); fetch_req = 1'b0;
        repeat (49) tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        check("abort_idle_ready", int'(wr_ready), 1);
        check("abort_idle_addr", int'(mem_addr), 0);
        n_done = 0;
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            if (fetch_done) n_done++;
            tick();
        end
        check("abort_no_done", n_done, 0);
        fetch_req = 1'b1; fetch_row = 7'd0;
        tick(); fetch_req = 1'b0;
        wait_done(200);

        // Randomized traffic; writer holds its request until accepted.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            acc = wr_valid && wr_ready;
            tick();
            rst       = ($urandom_range(0, 999) == 0);
            fetch_req = ($urandom_range(0, 59) == 0);
            fetch_row = 7'($urandom_range(0, 127));
            vid_rd_x  = 8'($urandom_range(0, 255));
            if (!wr_valid || acc) begin
                wr_valid = ($urandom_range(0, 2) != 0);
                wr_addr  = 15'($urandom_range(0, 19300));
                wr_data  = 3'($urandom_range(0, 7));
            end
        end
        rst = 1'b0; fetch_req = 1'b0; wr_valid = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
